// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Holds the core operation encodings, the controller state enum and the
// requester identifiers used by the arbiter and the controller.
package dm_ctrl_pkg;

    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_PUSH  = 3'd3;
    localparam logic [2:0] OP_POP   = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_LDR  = 1'b1
    } req_id_e;

endpackage

// File: rtl/dm_rr_arb.sv
// Two-way round-robin arbiter between the core and the loader.
// Ports:
//   req[1:0]    request vector, bit 0 = core, bit 1 = loader
//   last_grant  requester served most recently
//   enable      arbitration allowed this cycle (controller idle)
//   grant[1:0]  one-hot grant, same bit order as req; zero when disabled
module dm_rr_arb
    import dm_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // On a tie the requester that was not served last wins, so a
    // continuously requesting loser is always next in line.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = (last_grant == REQ_LDR) ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer for the 16-bit core.
// Arbitrates core LOAD/STORE/PUSH/POP and loader reads/writes onto one
// single-port memory with 1-cycle registered read latency, owns the stack
// pointer and flags push overflow / pop underflow.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   core_req/op/addr/wdata        core request (held until core_ack)
//   core_ack                      one-cycle core completion pulse
//   ldr_req/we/addr/wdata         loader request (held until ldr_ack)
//   ldr_ack                       one-cycle loader completion pulse
//   rd_data                       read data, valid only in the ack cycle
//   sp                            current stack pointer
//   clr_flags, stack_ovf/unf      sticky stack error flags and their clear
//   mem_en/we/addr/wdata/rdata    memory array interface
module dm_access_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter logic [15:0] STACK_BASE  = 16'hFFFF,
    parameter logic [15:0] STACK_LIMIT = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic [2:0]  core_op,
    input  logic [8:0]  core_addr,
    input  logic [15:0] core_wdata,
    output logic        core_ack,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [15:0] ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic        ldr_ack,
    output logic [15:0] rd_data,
    output logic [15:0] sp,
    input  logic        clr_flags,
    output logic        stack_ovf,
    output logic        stack_unf,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    state_e      state;
    state_e      next_state;
    req_id_e     last_grant;
    req_id_e     lock_who;
    logic        lock_read;
    logic        lock_push;
    logic        lock_pop;
    logic        lock_ovf;
    logic        lock_unf;
    logic        rd_sel;
    logic [1:0]  grant;

    logic        acc;
    logic        acc_we;
    logic        acc_read;
    logic        acc_push;
    logic        acc_pop;
    logic        acc_ovf;
    logic        acc_unf;
    logic [15:0] acc_addr;
    logic [15:0] acc_wdata;

    dm_rr_arb u_arb (
        .req        ({ldr_req, core_req}),
        .last_grant (last_grant),
        .enable     (state == IDLE),
        .grant      (grant)
    );

    // Fixed three-cycle sequence: grant, memory strobe, acknowledge.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = (grant != 2'b00) ? MEM : IDLE;
            MEM:     next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Decode the granted request into a memory access and its side effects.
    // Out-of-bounds stack ops and illegal core ops produce no access; they
    // only record the flag to raise when the op is acknowledged.
    always_comb begin
        acc       = 1'b0;
        acc_we    = 1'b0;
        acc_read  = 1'b0;
        acc_push  = 1'b0;
        acc_pop   = 1'b0;
        acc_ovf   = 1'b0;
        acc_unf   = 1'b0;
        acc_addr  = 16'h0000;
        acc_wdata = 16'h0000;
        if (grant[1]) begin
            acc       = 1'b1;
            acc_we    = ldr_we;
            acc_read  = ~ldr_we;
            acc_addr  = ldr_addr;
            acc_wdata = ldr_wdata;
        end else if (grant[0]) begin
            case (core_op)
                OP_LOAD: begin
                    acc      = 1'b1;
                    acc_read = 1'b1;
                    acc_addr = {7'b0, core_addr};
                end
                OP_STORE: begin
                    acc       = 1'b1;
                    acc_we    = 1'b1;
                    acc_addr  = {7'b0, core_addr};
                    acc_wdata = core_wdata;
                end
                OP_PUSH: begin
                    if (sp >= STACK_LIMIT) begin
                        acc       = 1'b1;
                        acc_we    = 1'b1;
                        acc_push  = 1'b1;
                        acc_addr  = sp;
                        acc_wdata = core_wdata;
                    end else begin
                        acc_ovf = 1'b1;
                    end
                end
                OP_POP: begin
                    if (sp < STACK_BASE) begin
                        acc      = 1'b1;
                        acc_read = 1'b1;
                        acc_pop  = 1'b1;
                        acc_addr = sp + 16'd1;
                    end else begin
                        acc_unf = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register plus all registered outputs. The request is locked at
    // the grant edge, so later changes on the request ports are ignored
    // until the controller returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= REQ_LDR;
            lock_who   <= REQ_CORE;
            lock_read  <= 1'b0;
            lock_push  <= 1'b0;
            lock_pop   <= 1'b0;
            lock_ovf   <= 1'b0;
            lock_unf   <= 1'b0;
            rd_sel     <= 1'b0;
            core_ack   <= 1'b0;
            ldr_ack    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            sp         <= STACK_BASE;
            stack_ovf  <= 1'b0;
            stack_unf  <= 1'b0;
        end else begin
            state    <= next_state;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            core_ack <= 1'b0;
            ldr_ack  <= 1'b0;
            rd_sel   <= 1'b0;
            case (state)
                IDLE: begin
                    if (next_state == MEM) begin
                        lock_who  <= grant[1] ? REQ_LDR : REQ_CORE;
                        lock_read <= acc_read;
                        lock_push <= acc_push;
                        lock_pop  <= acc_pop;
                        lock_ovf  <= acc_ovf;
                        lock_unf  <= acc_unf;
                        mem_en    <= acc;
                        mem_we    <= acc & acc_we;
                        if (acc) begin
                            mem_addr  <= acc_addr;
                            mem_wdata <= acc_wdata;
                        end
                    end
                end
                MEM: begin
                    core_ack <= (lock_who == REQ_CORE);
                    ldr_ack  <= (lock_who == REQ_LDR);
                    rd_sel   <= lock_read;
                end
                RESP: begin
                    last_grant <= lock_who;
                    if (lock_push) begin
                        sp <= sp - 16'd1;
                    end else if (lock_pop) begin
                        sp <= sp + 16'd1;
                    end
                end
                default: ;
            endcase
            // A flag being raised this cycle takes priority over a clear.
            if (state == RESP && lock_ovf) begin
                stack_ovf <= 1'b1;
            end else if (clr_flags) begin
                stack_ovf <= 1'b0;
            end
            if (state == RESP && lock_unf) begin
                stack_unf <= 1'b1;
            end else if (clr_flags) begin
                stack_unf <= 1'b0;
            end
        end
    end

    // The memory output register already holds the read word during the
    // ack cycle; it is gated so rd_data is zero for writes and no-ops.
    assign rd_data = rd_sel ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl with a behavioural 64K x 16 memory.
module tb_dm_access_ctrl;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic [2:0]  core_op;
    logic [8:0]  core_addr;
    logic [15:0] core_wdata;
    logic        core_ack;
    logic        ldr_req;
    logic        ldr_we;
    logic [15:0] ldr_addr;
    logic [15:0] ldr_wdata;
    logic        ldr_ack;
    logic [15:0] rd_data;
    logic [15:0] sp;
    logic        clr_flags;
    logic        stack_ovf;
    logic        stack_unf;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        who;
        logic [15:0] rd;
        logic        mem;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } exp_t;

    exp_t sb[$];

    logic [15:0] mem_model [0:65535];

    dm_access_ctrl #(
        .STACK_BASE  (16'hFFFF),
        .STACK_LIMIT (16'hFFFE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_op    (core_op),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_ack    (ldr_ack),
        .rd_data    (rd_data),
        .sp         (sp),
        .clr_flags  (clr_flags),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_model[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem_model[mem_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every acknowledge pops one expectation; the memory strobe
    // seen in the preceding cycle is compared with the expected access.
    logic        prev_mem = 1'b0;
    logic        prev_we = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    logic [15:0] prev_wdata = 16'h0;
    logic        prev_ack = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_mem = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (prev_mem) checkOutput("mem_en_one_cycle", {15'b0, mem_en}, 16'h0);
            if (prev_ack) checkOutput("ack_one_cycle", {14'b0, core_ack, ldr_ack}, 16'h0);
            if (core_ack || ldr_ack) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_ack", {14'b0, core_ack, ldr_ack}, 16'h0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ack_who", {14'b0, core_ack, ldr_ack}, e.who ? 16'h1 : 16'h2);
                    checkOutput("rd_data", rd_data, e.rd);
                    checkOutput("mem_access", {15'b0, prev_mem}, {15'b0, e.mem});
                    if (e.mem) begin
                        checkOutput("mem_we", {15'b0, prev_we}, {15'b0, e.we});
                        checkOutput("mem_addr", prev_addr, e.addr);
                        if (e.we) checkOutput("mem_wdata", prev_wdata, e.wdata);
                    end
                end
            end
            prev_mem   = mem_en;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            prev_ack   = core_ack | ldr_ack;
        end
    end

    // Issue one request (who: 0 core, 1 loader), push its expected response
    // and wait for the acknowledge with a bounded cycle budget.
    task automatic applyStimulus(input logic who, input logic [2:0] op, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic we, input logic [15:0] exp_rd,
                                 input logic exp_mem, input logic exp_we, input logic [15:0] exp_addr);
        exp_t e;
        logic got;
        e.who = who; e.rd = exp_rd; e.mem = exp_mem; e.we = exp_we; e.addr = exp_addr; e.wdata = wdata;
        sb.push_back(e);
        if (who) begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            core_req = 1'b1; core_op = op; core_addr = addr[8:0]; core_wdata = wdata;
        end
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (who ? ldr_ack : core_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("ack_timeout", 16'h0, 16'h1);
        core_req = 1'b0;
        ldr_req  = 1'b0;
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        core_req = 1'b0; ldr_req = 1'b0; clr_flags = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_sp", sp, 16'hFFFF);
        checkOutput("rst_flags", {14'b0, stack_ovf, stack_unf}, 16'h0);
        checkOutput("rst_strobes", {12'b0, mem_en, mem_we, core_ack, ldr_ack}, 16'h0);
        checkOutput("rst_rd_data", rd_data, 16'h0);
        checkOutput("rst_mem_addr", mem_addr, 16'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 16'h0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acks;
        for (int i = 0; i < 65536; i++) mem_model[i] = 16'h0000;
        mem_rdata = 16'h0000;
        rst = 1'b1;
        core_req = 1'b0; core_op = 3'd0; core_addr = 9'h0; core_wdata = 16'h0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 16'h0; ldr_wdata = 16'h0;
        clr_flags = 1'b0;
        doReset();

        // Store then load through the core port.
        applyStimulus(1'b0, 3'd2, 16'h0005, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005);
        applyStimulus(1'b0, 3'd1, 16'h0005, 16'h0000, 1'b0, 16'hBEEF, 1'b1, 1'b0, 16'h0005);

        // Push, push, pop, pop.
        applyStimulus(1'b0, 3'd3, 16'h0000, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF);
        checkOutput("sp_push1", sp, 16'hFFFE);
        applyStimulus(1'b0, 3'd3, 16'h0000, 16'h5678, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE);
        checkOutput("sp_push2", sp, 16'hFFFD);
        applyStimulus(1'b0, 3'd4, 16'h0000, 16'h0000, 1'b0, 16'h5678, 1'b1, 1'b0, 16'hFFFE);
        checkOutput("sp_pop1", sp, 16'hFFFE);
        applyStimulus(1'b0, 3'd4, 16'h0000, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b0, 16'hFFFF);
        checkOutput("sp_pop2", sp, 16'hFFFF);
        checkOutput("flags_after_stack", {14'b0, stack_ovf, stack_unf}, 16'h0);

        // Pop on an empty stack right after reset.
        doReset();
        applyStimulus(1'b0, 3'd4, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        checkOutput("unf_set", {15'b0, stack_unf}, 16'h1);
        checkOutput("unf_sp", sp, 16'hFFFF);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        checkOutput("unf_cleared", {15'b0, stack_unf}, 16'h0);

        // Third push hits the stack limit of FFFE.
        applyStimulus(1'b0, 3'd3, 16'h0000, 16'hAAAA, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF);
        applyStimulus(1'b0, 3'd3, 16'h0000, 16'hBBBB, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE);
        applyStimulus(1'b0, 3'd3, 16'h0000, 16'hCCCC, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        checkOutput("ovf_set", {15'b0, stack_ovf}, 16'h1);
        checkOutput("ovf_sp", sp, 16'hFFFD);
        checkOutput("ovf_no_write", mem_model[16'hFFFD], 16'h0000);

        // Illegal opcode: ack only, flags untouched.
        applyStimulus(1'b0, 3'd7, 16'h0005, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        checkOutput("illegal_flags", {14'b0, stack_ovf, stack_unf}, 16'h2);
        checkOutput("illegal_sp", sp, 16'hFFFD);

        // Both requesters held high: core, loader, core, loader.
        doReset();
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e.who = 1'b0; e.rd = 16'hBEEF; e.mem = 1'b1; e.we = 1'b0; e.addr = 16'h0005; e.wdata = 16'h0;
            sb.push_back(e);
            e.who = 1'b1; e.rd = 16'h0000; e.mem = 1'b1; e.we = 1'b1; e.addr = 16'h0020; e.wdata = 16'hCAFE;
            sb.push_back(e);
        end
        core_req = 1'b1; core_op = 3'd1; core_addr = 9'h005; core_wdata = 16'h0;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0020; ldr_wdata = 16'hCAFE;
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (core_ack || ldr_ack) acks++;
            if (acks == 4) break;
        end
        core_req = 1'b0; ldr_req = 1'b0;
        @(negedge clk);
        checkOutput("rr_ack_count", acks[15:0], 16'd4);
        checkOutput("rr_sb_empty", sb.size() == 0 ? 16'h0 : 16'h1, 16'h0);
        checkOutput("rr_ldr_write", mem_model[16'h0020], 16'hCAFE);

        // Reset while a loader write is strobing memory.
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0040; ldr_wdata = 16'h5A5A;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (mem_en) begin
                    seen = 1'b1;
                    break;
                end
            end
            checkOutput("abort_mem_seen", {15'b0, seen}, 16'h1);
        end
        rst = 1'b1;
        #1;
        checkOutput("abort_mem_en", {15'b0, mem_en}, 16'h0);
        checkOutput("abort_ldr_ack", {15'b0, ldr_ack}, 16'h0);
        ldr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort_sp", sp, 16'hFFFF);
        applyStimulus(1'b0, 3'd1, 16'h0005, 16'h0000, 1'b0, 16'hBEEF, 1'b1, 1'b0, 16'h0005);
        applyStimulus(1'b1, 3'd0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040);
        checkOutput("final_sb_empty", sb.size() == 0 ? 16'h0 : 16'h1, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
